da_tap_feeder: RTL and testbench
================================

DA_TAP_FEEDER -- requirements
Module: da_tap_feeder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, input FIFO entries; power of two, 2..16.
REQ-002 Parameter FRAME_LEN, default 6, clocks per DA frame (load + 4 bit-serial steps + output); range 3..15.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately.
REQ-005 x_in  input  4  signed two's-complement input sample.
REQ-006 x_valid  input  1  x_in valid this cycle.
REQ-007 x_ready  output  1  block accepts a sample this cycle; equals NOT fifo_full.
REQ-008 x_in0, x_in1, x_in2  output  4 each  registered tap outputs to the DA stage; x_in0 = newest sample, x_in2 = oldest.
REQ-009 frame_start  output  1  one-cycle pulse in the first cycle the taps hold new values.
REQ-010 taps_valid  output  1  high once three real samples occupy the delay line.
REQ-011 underrun  output  1  one-cycle pulse when a frame boundary finds the FIFO empty in state RUN.

Function
REQ-012 Push: x_valid AND x_ready at a rising edge writes x_in to the FIFO tail; samples are never dropped while x_ready is high.
REQ-013 x_ready is combinational from the registered full flag only, with no bypass; a pop in the same cycle does not raise x_ready until the next cycle.
REQ-014 Frame counter fc counts 0..FRAME_LEN-1 and wraps to 0; the boundary is the edge where fc = FRAME_LEN-1.
REQ-015 Pop occurs only at a boundary and only if the FIFO held at least one entry before that edge; a same-edge push is not eligible.
REQ-016 On pop: x_in2 <= x_in1, x_in1 <= x_in0, x_in0 <= FIFO head; all three taps update on the same edge.
REQ-017 frame_start is asserted in the cycle after every boundary edge, regardless of pop or underrun, so the DA stage loads on it.
REQ-018 Taps are held constant for all other cycles of the frame.
REQ-019 State EMPTY: no samples shifted. On the first pop go to FILL with fill count 1.
REQ-020 State FILL: each pop increments the fill count; on the third pop go to RUN; a boundary with an empty FIFO leaves the taps and fill count unchanged and does not pulse underrun.
REQ-021 State RUN: taps_valid = 1.
  - A boundary with an empty FIFO shifts in 0 (x_in0 <= 0, older taps advance) and pulses underrun in the frame_start cycle.
  - RUN has no exit except reset.
REQ-022 taps_valid = 0 in EMPTY and FILL.
REQ-023 Latency: a sample pushed into an empty FIFO appears on x_in0 at the first boundary strictly after its push edge, i.e. 1..FRAME_LEN cycles later.
REQ-024 FIFO pointers are log2(FIFO_DEPTH)+1 bits wide.
  - full = pointers differ only in MSB; empty = pointers equal.
  - Wrap-around shall be seamless.
REQ-025 Simultaneous push and pop with the FIFO not full: occupancy is unchanged and ordering is preserved.

Reset
REQ-026 While reset = 0: taps = 0, fc = 0, FIFO empty, state EMPTY, frame_start = 0, underrun = 0, taps_valid = 0, x_ready = 1.
REQ-027 Reset asserted mid-frame or mid-FILL discards FIFO contents and the partial fill; after release fc restarts at 0 and the first boundary is FRAME_LEN edges later.

Configuration
REQ-028 Macro DA_FEEDER_UNDERRUN_CNT_EN defined: an added output underrun_cnt (8 bits, unsigned) counts underrun pulses, saturates at 255, and resets to 0.
REQ-029 Macro DA_FEEDER_UNDERRUN_CNT_EN undefined: port underrun_cnt and its logic are absent; all other behaviour is identical.

Verification
REQ-030 Reset, then push 1, 2, 3 back-to-back with defaults.
  - After the third boundary: x_in0 = 3, x_in1 = 2, x_in2 = 1, taps_valid = 1.
  - frame_start pulses every 6 cycles.
REQ-031 Push 5 samples with the FIFO never popping.
  - x_ready drops after the 4th accept.
  - The 5th sample is held off by the source and accepted in the cycle after the next boundary pop.
REQ-032 In RUN with taps 3/2/1, supply no data for one frame.
  - Next taps: x_in0 = 0, x_in1 = 3, x_in2 = 2.
  - underrun pulses once; underrun_cnt = 1 when the macro is enabled.
REQ-033 Push -8 (1000b) and 7 (0111b).
  - Taps carry the exact bit patterns; no sign alteration.
REQ-034 Assert reset at fc = 3 in FILL with 2 queued samples.
  - All outputs return to reset values immediately.
  - The first post-reset frame_start occurs 6 cycles after release.
REQ-035 Run 40 pushes with random x_valid gaps.
  - Scoreboard: taps sequence equals the input order, with zeros only at flagged underruns.
  - FIFO pointers wrap at least 8 times.

Source files
------------

// File: rtl/da_tap_feeder.sv
// Sample FIFO plus a three-tap delay line that shifts once per DA frame boundary.
// Optional DA_FEEDER_UNDERRUN_CNT_EN adds an 8-bit saturating underrun counter output.
module da_tap_feeder #(
   parameter int FIFO_DEPTH = 4,
   parameter int FRAME_LEN  = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] x_in,
   input  logic       x_valid,
   output logic       x_ready,
   output logic [3:0] x_in0,
   output logic [3:0] x_in1,
   output logic [3:0] x_in2,
   output logic       frame_start,
   output logic       taps_valid,
   output logic       underrun
`ifdef DA_FEEDER_UNDERRUN_CNT_EN
   ,
   output logic [7:0] underrun_cnt
`endif
);

   localparam int         AW      = $clog2(FIFO_DEPTH);
   localparam logic [3:0] FC_LAST = 4'(FRAME_LEN - 1);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   typedef enum logic [1:0] {
      S_EMPTY,
      S_FILL,
      S_RUN
   } state_t;

   logic [3:0]  mem_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [3:0]  fc_q, fc_d;
   logic [3:0]  tap0_q, tap1_q, tap2_q;
   logic [1:0]  fill_q;
   state_t      state_q;
   logic        frame_start_q, underrun_q, taps_valid_q;
`ifdef DA_FEEDER_UNDERRUN_CNT_EN
   logic [7:0]  underrun_cnt_q;
`endif

   logic full, empty, push, boundary, pop;

   // Flags come only from registered pointers, so a same-edge pop never bypasses into x_ready.
   assign full     = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign x_ready  = ~full;
   assign push     = x_valid & ~full;
   assign boundary = (fc_q == FC_LAST);
   assign pop      = boundary & ~empty;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fc_d     = fc_q + 4'd1;
      if (push)     wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)      rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (boundary) fc_d     = '0;
   end

   // NOTE: sample storage has no reset; the reset pointers already mark it empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= x_in;
   end

   // NOTE: sequential state uses non-blocking assignments only, so all taps shift on one edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fc_q          <= '0;
         tap0_q        <= '0;
         tap1_q        <= '0;
         tap2_q        <= '0;
         fill_q        <= '0;
         state_q       <= S_EMPTY;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
         taps_valid_q  <= 1'b0;
`ifdef DA_FEEDER_UNDERRUN_CNT_EN
         underrun_cnt_q <= '0;
`endif
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         fc_q          <= fc_d;
         frame_start_q <= boundary;
         underrun_q    <= 1'b0;
         if (pop) begin
            tap2_q <= tap1_q;
            tap1_q <= tap0_q;
            tap0_q <= mem_q[rd_ptr_q[AW-1:0]];
            case (state_q)
               S_EMPTY: begin
                  state_q <= S_FILL;
                  fill_q  <= 2'd1;
               end
               S_FILL: begin
                  fill_q <= fill_q + 2'd1;
                  if (fill_q == 2'd2) begin
                     state_q      <= S_RUN;
                     taps_valid_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end else if (boundary && state_q == S_RUN) begin
            // Starved frame in RUN: keep the line moving with a zero sample.
            tap2_q     <= tap1_q;
            tap1_q     <= tap0_q;
            tap0_q     <= '0;
            underrun_q <= 1'b1;
`ifdef DA_FEEDER_UNDERRUN_CNT_EN
            if (underrun_cnt_q != 8'hFF) underrun_cnt_q <= underrun_cnt_q + 8'd1;
`endif
         end
      end
   end

   assign x_in0       = tap0_q;
   assign x_in1       = tap1_q;
   assign x_in2       = tap2_q;
   assign frame_start = frame_start_q;
   assign underrun    = underrun_q;
   assign taps_valid  = taps_valid_q;
`ifdef DA_FEEDER_UNDERRUN_CNT_EN
   assign underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_da_tap_feeder.sv
// Directed bench for da_tap_feeder (defaults: depth 4, frame 6), closing with a
// reference-model run of 40 randomly gapped pushes.
module tb_da_tap_feeder;

   logic       clk     = 1'b0;
   logic       reset   = 1'b0;
   logic [3:0] x_in    = '0;
   logic       x_valid = 1'b0;
   logic       x_ready;
   logic [3:0] x_in0, x_in1, x_in2;
   logic       frame_start, taps_valid, underrun;
`ifdef DA_FEEDER_UNDERRUN_CNT_EN
   logic [7:0] underrun_cnt;
`endif

   int passed = 0;
   int total  = 0;

   da_tap_feeder dut (
      .clk         (clk),
      .reset       (reset),
      .x_in        (x_in),
      .x_valid     (x_valid),
      .x_ready     (x_ready),
      .x_in0       (x_in0),
      .x_in1       (x_in1),
      .x_in2       (x_in2),
      .frame_start (frame_start),
      .taps_valid  (taps_valid),
      .underrun    (underrun)
`ifdef DA_FEEDER_UNDERRUN_CNT_EN
      ,
      .underrun_cnt(underrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_taps(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                           input logic [3:0] e2);
      check({tag, ".x_in0"}, 8'(x_in0), 8'(e0));
      check({tag, ".x_in1"}, 8'(x_in1), 8'(e1));
      check({tag, ".x_in2"}, 8'(x_in2), 8'(e2));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] q[$];
      logic [3:0] m0, m1, m2, val;
      int         mfc, mfill, pushes, und_total;
      bit         acc, bnd, mpop, mund, done;

      // Reset values
      #2;
      check("rst.x_ready", 8'(x_ready), 8'(1));
      chk_taps("rst", 4'd0, 4'd0, 4'd0);
      check("rst.frame_start", 8'(frame_start), 8'(0));
      check("rst.taps_valid", 8'(taps_valid), 8'(0));
      check("rst.underrun", 8'(underrun), 8'(0));
`ifdef DA_FEEDER_UNDERRUN_CNT_EN
      check("rst.underrun_cnt", underrun_cnt, 8'd0);
`endif
      @(negedge clk);
      reset = 1'b1;

      // Fill with 1,2,3; boundaries at edges 6, 12, 18
      x_valid = 1'b1;
      x_in    = 4'd1;
      for (int i = 1; i <= 18; i++) begin
         tick();
         if (i == 1) x_in = 4'd2;
         if (i == 2) x_in = 4'd3;
         if (i == 3) begin
            x_valid = 1'b0;
            check("fill.x_ready", 8'(x_ready), 8'(1));
         end
         check("fill.frame_start", 8'(frame_start), 8'(i % 6 == 0));
         if (i == 6) begin
            chk_taps("fill1", 4'd1, 4'd0, 4'd0);
            check("fill1.taps_valid", 8'(taps_valid), 8'(0));
         end
         if (i == 12) begin
            chk_taps("fill2", 4'd2, 4'd1, 4'd0);
            check("fill2.taps_valid", 8'(taps_valid), 8'(0));
            check("fill2.underrun", 8'(underrun), 8'(0));
         end
         if (i == 18) begin
            chk_taps("fill3", 4'd3, 4'd2, 4'd1);
            check("fill3.taps_valid", 8'(taps_valid), 8'(1));
         end
      end

      // One starved frame in RUN
      repeat (5) tick();
      check("und.pre", 8'(underrun), 8'(0));
      tick();
      check("und.pulse", 8'(underrun), 8'(1));
      check("und.frame_start", 8'(frame_start), 8'(1));
      chk_taps("und", 4'd0, 4'd3, 4'd2);
`ifdef DA_FEEDER_UNDERRUN_CNT_EN
      check("und.underrun_cnt", underrun_cnt, 8'd1);
`endif
      tick();
      check("und.once", 8'(underrun), 8'(0));
      check("und.fs_low", 8'(frame_start), 8'(0));

      // Back-pressure: edges 26..29 push 10..13, 14 is held off
      x_valid = 1'b1;
      x_in    = 4'd10;
      for (int j = 0; j < 4; j++) begin
         check("bp.ready_before", 8'(x_ready), 8'(1));
         tick();
         x_in = 4'(11 + j);
      end
      check("bp.ready_drop", 8'(x_ready), 8'(0));
      tick();
      chk_taps("bp.pop", 4'd10, 4'd0, 4'd3);
      check("bp.ready_after_pop", 8'(x_ready), 8'(1));
      tick();
      x_valid = 1'b0;
      check("bp.fifth_accepted", 8'(x_ready), 8'(0));
      repeat (23) tick();
      chk_taps("bp.drain", 4'd14, 4'd13, 4'd12);
      check("bp.drain.x_ready", 8'(x_ready), 8'(1));

      // Extreme codes pass through untouched
      x_valid = 1'b1;
      x_in    = 4'b1000;
      tick();
      x_in = 4'b0111;
      tick();
      x_valid = 1'b0;
      repeat (4) tick();
      chk_taps("sign1", 4'b1000, 4'd14, 4'd13);
      repeat (6) tick();
      chk_taps("sign2", 4'b0111, 4'b1000, 4'd14);

      // Reset mid-FILL with two samples queued
      #2 reset = 1'b0;
      @(negedge clk);
      reset   = 1'b1;
      x_valid = 1'b1;
      x_in    = 4'd4;
      tick();
      x_in = 4'd5;
      tick();
      x_in = 4'd6;
      tick();
      x_valid = 1'b0;
      repeat (3) tick();
      check("rst2.pre.x_in0", 8'(x_in0), 8'(4));
      repeat (3) tick();
      #2 reset = 1'b0;
      #1;
      chk_taps("rst2.async", 4'd0, 4'd0, 4'd0);
      check("rst2.frame_start", 8'(frame_start), 8'(0));
      check("rst2.taps_valid", 8'(taps_valid), 8'(0));
      check("rst2.underrun", 8'(underrun), 8'(0));
      check("rst2.x_ready", 8'(x_ready), 8'(1));
`ifdef DA_FEEDER_UNDERRUN_CNT_EN
      check("rst2.underrun_cnt", underrun_cnt, 8'd0);
`endif
      @(negedge clk);
      reset = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check("rst2.first_fs", 8'(frame_start), 8'(i == 6));
      end
      check("rst2.discard.x_in0", 8'(x_in0), 8'(0));
      check("rst2.discard.taps_valid", 8'(taps_valid), 8'(0));

      // Randomly gapped stream against a reference model
      mfc = 0; mfill = 0; pushes = 0; und_total = 0; done = 1'b0;
      m0 = '0; m1 = '0; m2 = '0;
      for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
         if (pushes < 40)
            x_valid = ($urandom_range(0, 15) < (((cyc / 48) % 2) != 0 ? 15 : 2));
         else
            x_valid = 1'b0;
         x_in = 4'($urandom_range(0, 15));
         val  = x_in;
         check("rnd.x_ready", 8'(x_ready), 8'(q.size() < 4));
         acc  = x_valid && (q.size() < 4);
         bnd  = (mfc == 5);
         mpop = bnd && (q.size() > 0);
         mund = 1'b0;
         tick();
         if (mpop) begin
            m2 = m1; m1 = m0; m0 = q.pop_front();
            if (mfill < 3) mfill++;
         end else if (bnd && mfill == 3) begin
            m2 = m1; m1 = m0; m0 = '0;
            mund = 1'b1;
            und_total++;
         end
         if (acc) begin
            q.push_back(val);
            pushes++;
         end
         mfc = bnd ? 0 : mfc + 1;
         check("rnd.frame_start", 8'(frame_start), 8'(bnd));
         check("rnd.underrun", 8'(underrun), 8'(mund));
         check("rnd.taps_valid", 8'(taps_valid), 8'(mfill == 3));
         chk_taps("rnd", m0, m1, m2);
         if (pushes == 40 && q.size() == 0 && mpop) done = 1'b1;
      end
      x_valid = 1'b0;
      check("rnd.completed", 8'(done), 8'(1));
`ifdef DA_FEEDER_UNDERRUN_CNT_EN
      check("rnd.underrun_cnt", underrun_cnt, 8'(und_total > 255 ? 255 : und_total));
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
